ysyx_23060203_lsu: RTL

- Load/store stage between EXU and WBU in the ysyx_23060203 pipelined RV32 core.
- Accepts one EXU result per handshake and issues at most one data-memory transaction per instruction.
- Aligns and sign/zero-extends load data, builds store strobes, and hands a registered result to WBU over a valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/ysyx_23060203_lsu_pkg.sv | 41 ++++
 rtl/ysyx_23060203_lsu_align.sv | 43 ++++
 rtl/ysyx_23060203_lsu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_lsu_pkg.sv
// Shared types and encodings for the ysyx_23060203 load/store unit.
// Holds the control bundle layout, funct3 codes, access sizes and FSM states.
package ysyx_23060203_lsu_pkg;

    localparam int CTRL_W = 80;

    typedef struct packed {
        logic [31:0] pc;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        exc;
        logic        ret;
        logic        fencei;
    } ctrl_t;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

    // funct3[1:0] already encodes the width; the unused code 11 maps to word.
    function automatic logic [1:0] funct_size(input logic [2:0] funct);
        case (funct[1:0])
            2'b00:   funct_size = SZ_B;
            2'b01:   funct_size = SZ_H;
            default: funct_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060203_lsu_align.sv
// Combinational data alignment: store lane shift and strobes, load extract and extend.
module ysyx_23060203_lsu_align
    import ysyx_23060203_lsu_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [1:0]  size,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = 8'(rdata >> {addr_lo, 3'b000});
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct)
            F_LB:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F_LH:    ld_data = {{16{ld_half[15]}}, ld_half};
            F_LW:    ld_data = rdata;
            F_LBU:   ld_data = {24'h0, ld_byte};
            F_LHU:   ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

    always_comb begin
        st_wdata = wdata << {addr_lo, 3'b000};
        case (funct)
            F_SB:    st_wstrb = 4'b0001 << addr_lo;
            F_SH:    st_wstrb = 4'b0011 << addr_lo;
            F_SW:    st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    assign size = funct_size(funct);

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// Load/store stage between EXU and WBU: one bus transaction per memory instruction,
// single-cycle passthrough for everything else, registered result toward WBU.
module ysyx_23060203_lsu #(
    parameter int ADDR_W = 32,
    parameter int CTRL_W = 80
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [4:0]        in_gpr_waddr,
    input  logic [31:0]       in_gpr_wdata,
    input  logic              in_mem_ren,
    input  logic              in_mem_wen,
    input  logic [2:0]        in_mem_funct,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [31:0]       in_mem_wdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [ADDR_W-1:0] req_addr,
    output logic [31:0]       req_wdata,
    output logic [3:0]        req_wstrb,
    output logic [1:0]        req_size,
    input  logic              resp_valid,
    input  logic [31:0]       resp_rdata,
    input  logic              resp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_gpr_waddr,
    output logic [31:0]       out_gpr_wdata
);

    import ysyx_23060203_lsu_pkg::*;

    lsu_state_e        state;
    logic              l_wen;
    logic [2:0]        l_funct;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_sdata;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [1:0]  size;
    logic [31:0] ld_data;
    logic        accept;
    logic        is_mem;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_mem_ren || in_mem_wen;

    ysyx_23060203_lsu_align u_align (
        .funct   (l_funct),
        .addr_lo (l_addr[1:0]),
        .wdata   (l_sdata),
        .rdata   (resp_rdata),
        .st_wdata(st_wdata),
        .st_wstrb(st_wstrb),
        .size    (size),
        .ld_data (ld_data)
    );

    // Request fields come straight from the latched instruction, so they hold through a stall.
    assign req_valid = (state == REQ);
    assign req_wen   = l_wen;
    assign req_addr  = l_addr;
    assign req_wdata = l_wen ? st_wdata : 32'h0;
    assign req_wstrb = l_wen ? st_wstrb : 4'h0;
    assign req_size  = size;

    // ctrl/waddr/wdata go straight into the output register on accept; for memory
    // ops out_valid stays low until the response patches in load data or the error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_ctrl      <= '0;
            out_gpr_waddr <= 5'h0;
            out_gpr_wdata <= 32'h0;
            l_wen         <= 1'b0;
            l_funct       <= 3'h0;
            l_addr        <= '0;
            l_sdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_ctrl      <= in_ctrl;
                        out_gpr_waddr <= in_gpr_waddr;
                        out_gpr_wdata <= in_gpr_wdata;
                        out_valid     <= !is_mem;
                        if (is_mem) begin
                            state   <= REQ;
                            l_wen   <= in_mem_wen;
                            l_funct <= in_mem_funct;
                            l_addr  <= in_mem_addr;
                            l_sdata <= in_mem_wdata;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (resp_valid) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        if (resp_err) out_gpr_waddr <= 5'h0;
                        if (!l_wen)   out_gpr_wdata <= ld_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic misaligned;
    always_comb begin
        case (funct_size(in_mem_funct))
            SZ_H:    misaligned = in_mem_addr[0];
            SZ_W:    misaligned = |in_mem_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assert property (@(posedge clock) disable iff (!reset) !(accept && is_mem && misaligned))
        else $error("lsu: misaligned half/word access");
`endif

endmodule
